box_h_window_sequencer: RTL and testbench

Front-end controller for the horizontal fp16 box/convolution datapath. It consumes a raster pixel stream, holds the 1 x WINDOW_WIDTH sliding window, and zero-pads the left and right image borders. It drives window_i, col_i, row_i and valid_i of the downstream convolution instance. Input stalls with ready_o only while it flushes the right border at end of line; the datapath itself has no backpressure.

---
 rtl/box_h_window_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_box_h_window_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/box_h_window_sequencer.sv
// box_h_window_sequencer
// Front end of the horizontal fp16 box/convolution datapath. It takes a raster
// pixel stream and keeps a 1 x WINDOW_WIDTH sliding window over it. The left
// and right image borders are padded with +0. It drives one window per output
// column to the convolution instance downstream.
//
// Ports:
//   clk_i, rst_i   clock; asynchronous active-high reset
//   clear_i        synchronous frame abort/restart (drops any pixel offered with it)
//   pixel_i        input pixel word; accepted when valid_i & ready_o
//   valid_i        pixel_i valid
//   ready_o        low only while the right border of a line is flushed
//   window_o       [0][0] = column c-R ... [0][W-1] = column c+R
//   col_o, row_o   centre column / row of window_o
//   valid_o        window_o/col_o/row_o valid
//   frame_done_o   one-cycle pulse with the last window of a frame
//   busy_o         frame in progress
module box_h_window_sequencer #(
    parameter int EXP_WIDTH    = 5,
    parameter int FRAC_WIDTH   = 10,
    parameter int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH,
    parameter int WINDOW_WIDTH = 3,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            clear_i,
    input  logic [FP_WIDTH_REG-1:0]                         pixel_i,
    input  logic                                            valid_i,
    output logic                                            ready_o,
    output logic [0:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0]  window_o,
    output logic [15:0]                                     col_o,
    output logic [15:0]                                     row_o,
    output logic                                            valid_o,
    output logic                                            frame_done_o,
    output logic                                            busy_o
);

    localparam int R = (WINDOW_WIDTH - 1) / 2;

    // One 17-bit position counter walks the whole line: FILL uses 0..R-1,
    // RUN R..IMAGE_WIDTH-1, FLUSH IMAGE_WIDTH..IMAGE_WIDTH+R-1. The emitted
    // centre column is always pos - R. The extra bit covers the flush tail
    // of a 65535-wide line.
    localparam logic [16:0] POS_FILL_LAST  = 17'(R - 1);
    localparam logic [16:0] POS_RUN_LAST   = 17'(IMAGE_WIDTH - 1);
    localparam logic [16:0] POS_FLUSH_LAST = 17'(IMAGE_WIDTH + R - 1);
    localparam logic [16:0] POS_R          = 17'(R);
    localparam logic [15:0] ROW_LAST       = 16'(IMAGE_HEIGHT - 1);

    if (IMAGE_WIDTH < WINDOW_WIDTH || IMAGE_WIDTH > 65535) begin : g_bad_width
        $error("IMAGE_WIDTH must be in [WINDOW_WIDTH, 65535]");
    end
    if (IMAGE_HEIGHT < 1 || IMAGE_HEIGHT > 65535) begin : g_bad_height
        $error("IMAGE_HEIGHT must be in [1, 65535]");
    end
    if (WINDOW_WIDTH < 3 || (WINDOW_WIDTH % 2) == 0) begin : g_bad_window
        $error("WINDOW_WIDTH must be odd and at least 3");
    end

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                                   state, state_nxt;
    logic [WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] shreg, shreg_shifted;
    logic [FP_WIDTH_REG-1:0]                  shift_in;
    logic                                     shift_en;
    logic [16:0]                              pos, pos_nxt;
    logic [15:0]                              row, row_nxt;
    logic                                     accept;
    logic                                     emit;
    logic                                     line_end;
    logic                                     frame_end;
    logic                                     frame_active;

    assign ready_o = (state != FLUSH);
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        row_nxt   = row;
        emit      = 1'b0;
        line_end  = 1'b0;
        frame_end = 1'b0;
        shift_en  = accept;
        shift_in  = pixel_i;
        case (state)
            FILL: begin
                if (accept) begin
                    pos_nxt = pos + 17'd1;
                    if (pos == POS_FILL_LAST) state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    emit    = 1'b1;
                    pos_nxt = pos + 17'd1;
                    if (pos == POS_RUN_LAST) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Right border: shift +0 in, one window per cycle, input stalled.
                emit     = 1'b1;
                shift_en = 1'b1;
                shift_in = '0;
                pos_nxt  = pos + 17'd1;
                if (pos == POS_FLUSH_LAST) begin
                    line_end  = 1'b1;
                    pos_nxt   = '0;
                    state_nxt = FILL;
                    if (row == ROW_LAST) begin
                        frame_end = 1'b1;
                        row_nxt   = '0;
                    end else begin
                        row_nxt = row + 16'd1;
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        for (int i = 0; i < WINDOW_WIDTH - 1; i++) shreg_shifted[i] = shreg[i+1];
        shreg_shifted[WINDOW_WIDTH-1] = shift_in;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= FILL;
            pos          <= '0;
            row          <= '0;
            shreg        <= '0;
            frame_active <= 1'b0;
            window_o     <= '0;
            col_o        <= '0;
            row_o        <= '0;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else if (clear_i) begin
            state        <= FILL;
            pos          <= '0;
            row          <= '0;
            shreg        <= '0;
            frame_active <= 1'b0;
            window_o     <= '0;
            col_o        <= '0;
            row_o        <= '0;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
            row   <= row_nxt;
            // The next line must start from +0 on the left border.
            if (line_end)      shreg <= '0;
            else if (shift_en) shreg <= shreg_shifted;
            valid_o      <= emit;
            frame_done_o <= frame_end;
            if (emit) begin
                window_o[0] <= shreg_shifted;
                col_o       <= 16'(pos - POS_R);
                row_o       <= row;
            end
            frame_active <= (frame_active && !frame_end) || accept;
            // Hold busy through the frame_done cycle and drop it for exactly the
            // following cycle. An accept made in that cycle starts the next frame,
            // so busy rises again one cycle later.
            busy_o <= !frame_done_o && (frame_active || accept);
        end
    end

endmodule

// File: tb/tb_box_h_window_sequencer.sv
module tb_box_h_window_sequencer;

    localparam int W3  = 3;
    localparam int R3  = 1;
    localparam int IW3 = 4;
    localparam int IH3 = 2;
    localparam int W5  = 5;
    localparam int IW5 = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Window 3 instance
    logic                        clr3 = 1'b0, v3 = 1'b0;
    logic [15:0]                 p3 = '0;
    logic                        ready3, valid3, fd3, busy3;
    logic [0:0][W3-1:0][15:0]    window3;
    logic [15:0]                 col3, row3;

    // Window 5 instance
    logic                        clr5 = 1'b0, v5 = 1'b0;
    logic [15:0]                 p5 = '0;
    logic                        ready5, valid5, fd5, busy5;
    logic [0:0][W5-1:0][15:0]    window5;
    logic [15:0]                 col5, row5;

    box_h_window_sequencer #(.WINDOW_WIDTH(W3), .IMAGE_WIDTH(IW3), .IMAGE_HEIGHT(IH3)) dut3 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr3), .pixel_i(p3), .valid_i(v3),
        .ready_o(ready3), .window_o(window3), .col_o(col3), .row_o(row3),
        .valid_o(valid3), .frame_done_o(fd3), .busy_o(busy3));

    box_h_window_sequencer #(.WINDOW_WIDTH(W5), .IMAGE_WIDTH(IW5), .IMAGE_HEIGHT(2)) dut5 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr5), .pixel_i(p5), .valid_i(v5),
        .ready_o(ready5), .window_o(window5), .col_o(col5), .row_o(row5),
        .valid_o(valid5), .frame_done_o(fd5), .busy_o(busy5));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: remembers the pixels of the current input line and
    // derives each window from the padded line, independent of input timing.
    logic [15:0] line_px [IW3];
    int          m_in_col, m_row, m_flush_left;
    bit          m_started, m_fd, m_busy;

    task automatic mreset();
        m_in_col = 0; m_row = 0; m_flush_left = 0;
        m_started = 0; m_fd = 0; m_busy = 0;
    endtask

    function automatic logic [15:0] lp(input int k);
        return (k < 0 || k >= IW3) ? 16'h0000 : line_px[k];
    endfunction

    // One clock of dut3: drive, predict, compare after the edge.
    task automatic cyc(input logic v, input logic [15:0] p, input logic clr);
        logic [W3-1:0][15:0] ew;
        logic ev, efd;
        int   ec, er;
        bit   prev_fd;
        v3 = v; p3 = p; clr3 = clr;
        #1;
        chk("ready", 128'(ready3), 128'(m_flush_left == 0));
        @(posedge clk);
        ev = 0; efd = 0; ec = 0; er = 0; ew = '0; prev_fd = m_fd;
        if (clr) begin
            mreset();
        end else begin
            if (m_flush_left > 0) begin
                ev = 1; ec = IW3 - m_flush_left; er = m_row;
                m_flush_left--;
                if (m_flush_left == 0) begin
                    efd = (m_row == IH3 - 1);
                    m_row = efd ? 0 : m_row + 1;
                    m_in_col = 0;
                end
            end else if (v) begin
                m_started = 1;
                line_px[m_in_col] = p;
                if (m_in_col >= R3) begin ev = 1; ec = m_in_col - R3; er = m_row; end
                m_in_col++;
                if (m_in_col == IW3) m_flush_left = R3;
            end
            if (ev) for (int i = 0; i < W3; i++) ew[i] = lp(ec - R3 + i);
            if (efd) m_started = 0;
            m_fd = efd;
            m_busy = prev_fd ? 1'b0 : (m_started || efd);
        end
        @(negedge clk);
        chk("valid", 128'(valid3), 128'(ev));
        chk("frame_done", 128'(fd3), 128'(efd));
        chk("busy", 128'(busy3), 128'(m_busy));
        if (ev) begin
            chk("window", 128'(window3), 128'(ew));
            chk("col", 128'(col3), 128'(ec));
            chk("row", 128'(row3), 128'(er));
        end
    endtask

    task automatic send(input logic [15:0] px[$], input int gap_pct);
        int   k, guard;
        logic v, rdy;
        k = 0; guard = 0;
        while (k < px.size()) begin
            v   = ($urandom_range(99) >= gap_pct);
            rdy = (m_flush_left == 0);
            cyc(v, px[k], 1'b0);
            if (v && rdy) k++;
            guard++;
            if (guard > 5000) begin
                chk("stream_timeout", 128'(0), 128'(1));
                break;
            end
        end
        while (m_flush_left > 0) cyc(1'b0, 16'h0, 1'b0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 128'(valid3), 128'(0));
        chk({tag, "_fd"}, 128'(fd3), 128'(0));
        chk({tag, "_busy"}, 128'(busy3), 128'(0));
        chk({tag, "_col"}, 128'(col3), 128'(0));
        chk({tag, "_row"}, 128'(row3), 128'(0));
        chk({tag, "_window"}, 128'(window3), 128'(0));
    endtask

    logic [15:0] q[$];
    logic [15:0] q5[IW5];

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1 chk_zero_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_reset", 128'(ready3), 128'(1));
        mreset();
        @(negedge clk);

        // Frame with the reference line values, continuous input
        q = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
        send(q, 0);
        cyc(1'b0, 16'h0, 1'b0);  // busy falls here
        cyc(1'b0, 16'h0, 1'b0);

        // Third line restarts at row 0
        q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        send(q, 0);
        // Row 1: two accepts, then clear with a pixel offered
        cyc(1'b1, 16'h5555, 1'b0);
        cyc(1'b1, 16'h6666, 1'b0);
        cyc(1'b1, 16'h7777, 1'b1);
        cyc(1'b0, 16'h0, 1'b0);
        q = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hB001, 16'hB002, 16'hB003, 16'hB004};
        send(q, 0);
        cyc(1'b0, 16'h0, 1'b0);

        // Two frames of random pixels with ~50% input gaps
        q = {};
        for (int i = 0; i < 2 * IW3 * IH3; i++) q.push_back(16'($urandom));
        send(q, 50);
        cyc(1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0);

        // Asynchronous reset while flushing the right border
        for (int i = 0; i < IW3; i++) cyc(1'b1, 16'(16'hC000 + i), 1'b0);
        chk("in_flush", 128'(ready3), 128'(0));
        v3 = 1'b0;
        #2 rst = 1'b1;
        #1 chk_zero_outputs("async_reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_async_reset", 128'(ready3), 128'(1));
        mreset();
        @(negedge clk);
        q = '{16'hD001, 16'hD002, 16'hD003, 16'hD004};
        send(q, 0);
        cyc(1'b0, 16'h0, 1'b0);

        // Window 5: two FILL accepts, two FLUSH cycles, padded edges
        begin
            int acc, nvalid, nready_low, ncol;
            logic [W5-1:0][15:0] e5;
            acc = 0; nvalid = 0; nready_low = 0; ncol = 0;
            for (int i = 0; i < IW5; i++) q5[i] = 16'($urandom_range(16'hFFFE) + 1);
            for (int n = 0; n < 10; n++) begin
                v5 = (acc < IW5);
                p5 = (acc < IW5) ? q5[acc] : 16'h0;
                #1;
                if (!ready5) nready_low++;
                @(posedge clk);
                if (v5 && ready5) acc++;
                @(negedge clk);
                chk("w5_valid_timing", 128'(valid5), 128'(n >= 2 && n <= 6));
                if (valid5) begin
                    nvalid++;
                    for (int i = 0; i < W5; i++) begin
                        int k;
                        k = ncol - 2 + i;
                        e5[i] = (k < 0 || k >= IW5) ? 16'h0 : q5[k];
                    end
                    chk("w5_window", 128'(window5), 128'(e5));
                    chk("w5_col", 128'(col5), 128'(ncol));
                    chk("w5_row", 128'(row5), 128'(0));
                    ncol++;
                end
            end
            v5 = 1'b0;
            chk("w5_nvalid", 128'(nvalid), 128'(IW5));
            chk("w5_flush_len", 128'(nready_low), 128'(2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
